// File: rtl/td4_control_sequencer_pkg.sv
// Shared opcodes, selector codes, FSM encodings and the decoded-control bundle
// for the TD4 fetch/decode/execute sequencer.
package td4_control_sequencer_pkg;

  localparam int PC_W  = 4;
  localparam int IMM_W = 4;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;
  localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;
  localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;
  localparam logic [OP_W-1:0] OP_MOV_AI = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;
  localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;
  localparam logic [OP_W-1:0] OP_MOV_BI = 4'b0111;
  localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;
  localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;
  localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;
  localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_IN   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef struct packed {
    logic [1:0]       sel;
    logic [IMM_W-1:0] imm;
    logic             ld_a;
    logic             ld_b;
    logic             ld_out;
    logic             ld_pc;
    logic             carry_we;
    logic             illegal;
  } ctrl_t;

  // Next program counter: jump target when a jump is taken, otherwise wrap-around increment.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc,
                                              input logic            jump,
                                              input logic [IMM_W-1:0] target);
    if (jump) begin
      pc_next = target;
    end else begin
      pc_next = pc + 4'd1;
    end
  endfunction

endpackage

// File: rtl/td4_control_sequencer_if.sv
// ROM fetch port plus datapath control bundle between the sequencer (master)
// and the register/selector/adder datapath (slave).
interface td4_control_sequencer_if;
  import td4_control_sequencer_pkg::*;

  logic [PC_W-1:0]  rom_addr;
  logic [7:0]       rom_data;
  logic             carry;
  logic [1:0]       sel;
  logic [IMM_W-1:0] imm;
  logic             ld_a;
  logic             ld_b;
  logic             ld_out;
  logic             ld_pc;
  logic             carry_we;
  logic             busy;
  logic             halted;

  modport master (
    input  rom_data, carry,
    output rom_addr, sel, imm, ld_a, ld_b, ld_out, ld_pc, carry_we, busy, halted
  );

  modport slave (
    output rom_data, carry,
    input  rom_addr, sel, imm, ld_a, ld_b, ld_out, ld_pc, carry_we, busy, halted
  );

endinterface

// File: rtl/td4_control_sequencer_decoder.sv
// Purely combinational instruction decoder: maps IR (and carry for JNC) onto
// selector code, immediate and load enables; flags the unused opcodes.
module td4_control_sequencer_decoder
  import td4_control_sequencer_pkg::*;
(
  input  logic [7:0] ir_i,
  input  logic       carry_i,
  output ctrl_t      ctrl_o
);

  // Opcode decode table; anything not listed is illegal and asserts nothing.
  always_comb begin
    ctrl_o.sel      = SEL_A;
    ctrl_o.imm      = ir_i[IMM_W-1:0];
    ctrl_o.ld_a     = 1'b0;
    ctrl_o.ld_b     = 1'b0;
    ctrl_o.ld_out   = 1'b0;
    ctrl_o.ld_pc    = 1'b0;
    ctrl_o.carry_we = 1'b0;
    ctrl_o.illegal  = 1'b0;
    case (ir_i[7:4])
      OP_ADD_A: begin
        ctrl_o.sel      = SEL_A;
        ctrl_o.ld_a     = 1'b1;
        ctrl_o.carry_we = 1'b1;
      end
      OP_ADD_B: begin
        ctrl_o.sel      = SEL_B;
        ctrl_o.ld_b     = 1'b1;
        ctrl_o.carry_we = 1'b1;
      end
      OP_MOV_AI: begin
        ctrl_o.sel  = SEL_ZERO;
        ctrl_o.ld_a = 1'b1;
      end
      OP_MOV_BI: begin
        ctrl_o.sel  = SEL_ZERO;
        ctrl_o.ld_b = 1'b1;
      end
      OP_MOV_AB: begin
        ctrl_o.sel  = SEL_B;
        ctrl_o.ld_a = 1'b1;
      end
      OP_MOV_BA: begin
        ctrl_o.sel  = SEL_A;
        ctrl_o.ld_b = 1'b1;
      end
      OP_IN_A: begin
        ctrl_o.sel  = SEL_IN;
        ctrl_o.ld_a = 1'b1;
      end
      OP_IN_B: begin
        ctrl_o.sel  = SEL_IN;
        ctrl_o.ld_b = 1'b1;
      end
      OP_OUT_B: begin
        ctrl_o.sel    = SEL_B;
        ctrl_o.ld_out = 1'b1;
      end
      OP_OUT_I: begin
        ctrl_o.sel    = SEL_ZERO;
        ctrl_o.ld_out = 1'b1;
      end
      OP_JMP: begin
        ctrl_o.sel   = SEL_ZERO;
        ctrl_o.ld_pc = 1'b1;
      end
      OP_JNC: begin
        ctrl_o.sel   = SEL_ZERO;
        ctrl_o.ld_pc = ~carry_i;
      end
      default: begin
        ctrl_o.imm     = 4'd0;
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/td4_control_sequencer.sv
// TD4 fetch/decode/execute sequencer: owns FSM, PC and IR; control outputs are
// the decoder result gated to the single EXEC cycle of each instruction.
module td4_control_sequencer
  import td4_control_sequencer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run_i,
  input  logic                          step_i,
  td4_control_sequencer_if.master       bus
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  ctrl_t           dec_s;
  ctrl_t           ctrl_s;
  logic            exec_s;

  td4_control_sequencer_decoder u_decoder (
    .ir_i    (ir_q),
    .carry_i (bus.carry),
    .ctrl_o  (dec_s)
  );

  assign exec_s = (state_q == ST_EXEC);

  // Next-state logic: step is only honoured in IDLE; HALT is left only by reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i || step_i) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_d    = bus.rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_s.illegal) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_next(pc_q, dec_s.ld_pc, dec_s.imm);
          if (run_i) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= 4'd0;
      ir_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Controls reach the datapath only during EXEC, so reset kills any pulse at once.
  always_comb begin
    if (exec_s) begin
      ctrl_s = dec_s;
    end else begin
      ctrl_s.sel      = SEL_A;
      ctrl_s.imm      = 4'd0;
      ctrl_s.ld_a     = 1'b0;
      ctrl_s.ld_b     = 1'b0;
      ctrl_s.ld_out   = 1'b0;
      ctrl_s.ld_pc    = 1'b0;
      ctrl_s.carry_we = 1'b0;
      ctrl_s.illegal  = 1'b0;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.sel      = ctrl_s.sel;
  assign bus.imm      = ctrl_s.imm;
  assign bus.ld_a     = ctrl_s.ld_a;
  assign bus.ld_b     = ctrl_s.ld_b;
  assign bus.ld_out   = ctrl_s.ld_out;
  assign bus.ld_pc    = ctrl_s.ld_pc;
  assign bus.carry_we = ctrl_s.carry_we;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_control_sequencer.sv
// Directed bench for td4_control_sequencer: ROM model in the bench, hand-computed
// control vectors {sel,imm,ld_a,ld_b,ld_out,ld_pc,carry_we,busy,halted}.
module tb_td4_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       carry_v = 1'b0;
  logic [7:0] rom [16];
  int         n_cmp = 0;
  int         n_err = 0;

  td4_control_sequencer_if bus ();

  assign bus.rom_data = rom[bus.rom_addr];
  assign bus.carry    = carry_v;

  td4_control_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (run),
    .step_i (step),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {bus.sel, bus.imm, bus.ld_a, bus.ld_b, bus.ld_out, bus.ld_pc,
                bus.carry_we, bus.busy, bus.halted};

  task automatic fill_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; carry_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset, start running and stop in the EXEC cycle of address k.
  task automatic run_to_exec(input int k);
    do_reset();
    run = 1'b1;
    repeat (2 * k + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    fill_rom();
    rst_n = 1'b0; run = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== 13'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", obs, 13'd0);
    end
    n_cmp++;
    if (bus.rom_addr !== 4'd0) begin
      n_err++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd0, 4'd0, 5'b00000, 2'b10} || bus.rom_addr !== 4'd0) begin
      n_err++; $display("FAIL reset_release_fetch: got %h/%0d want %h/0", obs, bus.rom_addr, {2'd0, 4'd0, 5'b00000, 2'b10});
    end
  endtask

  task automatic test_run();
    fill_rom();
    rom[0] = 8'b0011_0101;
    rom[1] = 8'b0000_0010;
    run_to_exec(0);
    n_cmp++;
    if (obs !== {2'd3, 4'd5, 5'b10000, 2'b10}) begin
      n_err++; $display("FAIL run_mov_a: got %h want %h", obs, {2'd3, 4'd5, 5'b10000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd0, 4'd0, 5'b00000, 2'b10} || bus.rom_addr !== 4'd1) begin
      n_err++; $display("FAIL run_fetch1: got %h/%0d want %h/1", obs, bus.rom_addr, {2'd0, 4'd0, 5'b00000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd0, 4'd2, 5'b10001, 2'b10}) begin
      n_err++; $display("FAIL run_add_a: got %h want %h", obs, {2'd0, 4'd2, 5'b10001, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rom_addr !== 4'd2) begin
      n_err++; $display("FAIL run_addr2: got %0d want 2", bus.rom_addr);
    end
  endtask

  task automatic test_jnc();
    fill_rom();
    rom[3] = 8'b1110_1010;
    run_to_exec(3);
    n_cmp++;
    if (obs !== {2'd3, 4'd10, 5'b00010, 2'b10}) begin
      n_err++; $display("FAIL jnc_taken: got %h want %h", obs, {2'd3, 4'd10, 5'b00010, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rom_addr !== 4'd10) begin
      n_err++; $display("FAIL jnc_taken_addr: got %0d want 10", bus.rom_addr);
    end
    run_to_exec(3);
    carry_v = 1'b1;
    #1;
    n_cmp++;
    if (obs !== {2'd3, 4'd10, 5'b00000, 2'b10}) begin
      n_err++; $display("FAIL jnc_not_taken: got %h want %h", obs, {2'd3, 4'd10, 5'b00000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rom_addr !== 4'd4) begin
      n_err++; $display("FAIL jnc_not_taken_addr: got %0d want 4", bus.rom_addr);
    end
  endtask

  task automatic test_wrap();
    fill_rom();
    rom[15] = 8'b0111_0000;
    run_to_exec(15);
    n_cmp++;
    if (obs !== {2'd3, 4'd0, 5'b01000, 2'b10}) begin
      n_err++; $display("FAIL wrap_mov_b: got %h want %h", obs, {2'd3, 4'd0, 5'b01000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rom_addr !== 4'd0 || obs !== {2'd0, 4'd0, 5'b00000, 2'b10}) begin
      n_err++; $display("FAIL wrap_addr: got %0d/%h want 0/%h", bus.rom_addr, obs, {2'd0, 4'd0, 5'b00000, 2'b10});
    end
  endtask

  task automatic test_step();
    fill_rom();
    rom[0] = 8'b0011_0101;
    do_reset();
    step = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd0, 4'd0, 5'b00000, 2'b10}) begin
      n_err++; $display("FAIL step_fetch: got %h want %h", obs, {2'd0, 4'd0, 5'b00000, 2'b10});
    end
    @(negedge clk);
    step = 1'b0;
    n_cmp++;
    if (obs !== {2'd3, 4'd5, 5'b10000, 2'b10}) begin
      n_err++; $display("FAIL step_exec: got %h want %h", obs, {2'd3, 4'd5, 5'b10000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== 13'd0 || bus.rom_addr !== 4'd1) begin
      n_err++; $display("FAIL step_idle: got %h/%0d want 0000/1", obs, bus.rom_addr);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 13'd0 || bus.rom_addr !== 4'd1) begin
      n_err++; $display("FAIL step_stays_idle: got %h/%0d want 0000/1", obs, bus.rom_addr);
    end
  endtask

  task automatic test_illegal();
    fill_rom();
    rom[2] = 8'b1100_0000;
    run_to_exec(2);
    n_cmp++;
    if (obs !== {2'd0, 4'd0, 5'b00000, 2'b10}) begin
      n_err++; $display("FAIL illegal_exec: got %h want %h", obs, {2'd0, 4'd0, 5'b00000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd0, 4'd0, 5'b00000, 2'b11} || bus.rom_addr !== 4'd2) begin
      n_err++; $display("FAIL illegal_halt: got %h/%0d want %h/2", obs, bus.rom_addr, {2'd0, 4'd0, 5'b00000, 2'b11});
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1; step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    n_cmp++;
    if (obs !== {2'd0, 4'd0, 5'b00000, 2'b11} || bus.rom_addr !== 4'd2) begin
      n_err++; $display("FAIL illegal_sticky: got %h/%0d want %h/2", obs, bus.rom_addr, {2'd0, 4'd0, 5'b00000, 2'b11});
    end
    do_reset();
    n_cmp++;
    if (obs !== 13'd0 || bus.rom_addr !== 4'd0) begin
      n_err++; $display("FAIL illegal_reset_clear: got %h/%0d want 0000/0", obs, bus.rom_addr);
    end
  endtask

  task automatic test_back_to_back();
    fill_rom();
    rom[0] = 8'b0011_0101;
    do_reset();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd3, 4'd5, 5'b10000, 2'b10}) begin
      n_err++; $display("FAIL run_drop_exec: got %h want %h", obs, {2'd3, 4'd5, 5'b10000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== 13'd0 || bus.rom_addr !== 4'd1) begin
      n_err++; $display("FAIL run_drop_idle: got %h/%0d want 0000/1", obs, bus.rom_addr);
    end
    run = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd3, 4'd0, 5'b10000, 2'b10}) begin
      n_err++; $display("FAIL run_step_exec: got %h want %h", obs, {2'd3, 4'd0, 5'b10000, 2'b10});
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {2'd0, 4'd0, 5'b00000, 2'b10} || bus.rom_addr !== 4'd2) begin
      n_err++; $display("FAIL run_step_continues: got %h/%0d want %h/2", obs, bus.rom_addr, {2'd0, 4'd0, 5'b00000, 2'b10});
    end
  endtask

  task automatic test_reset_mid();
    fill_rom();
    rom[0] = 8'b0011_0101;
    run_to_exec(0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 13'd0 || bus.rom_addr !== 4'd0) begin
      n_err++; $display("FAIL reset_mid_exec: got %h/%0d want 0000/0", obs, bus.rom_addr);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_run();
    test_jnc();
    test_wrap();
    test_step();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
